matrix_element_reader: RTL and testbench

- Sequential reader for the constant dictionary matrix delivered on a flat bus by the matrix ROM block.
- On request, streams one column (or one row, in transpose mode) as a sequence of 16-bit signed elements over a valid/ready handshake.
- Feeds the OMP correlation and projection datapaths, which consume one element per cycle.

---
 rtl/matrix_element_reader.sv | 152 +++++++++++++++
 tb/tb_matrix_element_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_element_reader.sv
// Streams one column or row of the flat dictionary matrix as WORD-bit elements.
// Optional running sum of squares per stream: define MATRIX_READER_NORM_EN.
module matrix_element_reader #(
  parameter int WORD = 16,
  parameter int ROWS = 24,
  parameter int COLS = 32,
  parameter int N    = WORD * ROWS * COLS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    mat_in,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [4:0]      req_idx,
  output logic            req_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic [4:0]      out_pos,
  output logic            out_last
`ifdef MATRIX_READER_NORM_EN
  ,
  output logic [2*WORD+5:0] norm_sq,
  output logic              norm_valid
`endif
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [5:0] ROWS6   = 6'(ROWS);
  localparam logic [5:0] COLS6   = 6'(COLS);
  localparam logic [4:0] LAST_C  = 5'(ROWS - 1);
  localparam logic [4:0] LAST_R  = 5'(COLS - 1);
  localparam logic [9:0] COLS10  = 10'(COLS);
  localparam logic [13:0] WORD14 = 14'(WORD);

  state_t    r_state;
  logic      r_mode;
  logic [4:0] r_idx;

  logic       w_idx_ok;
  logic       w_fire;
  logic       w_sel_mode;
  logic [4:0] w_sel_idx;
  logic [4:0] w_sel_pos;
  logic [4:0] w_sel_last;
  logic [9:0] w_addr;
  logic [13:0] w_base;
  logic [WORD-1:0] w_elem;

  // Address of the element to load next; invalid indices are forced to 0.
  always_comb begin
    w_idx_ok = req_mode ? ({1'b0, req_idx} < ROWS6)
                        : ({1'b0, req_idx} < COLS6);
    w_fire   = out_valid && out_ready;
    if (r_state == IDLE) begin
      w_sel_mode = req_mode;
      w_sel_idx  = w_idx_ok ? req_idx : 5'd0;
      w_sel_pos  = 5'd0;
    end else begin
      w_sel_mode = r_mode;
      w_sel_idx  = r_idx;
      w_sel_pos  = out_last ? 5'd0 : out_pos + 5'd1;
    end
    w_sel_last = w_sel_mode ? LAST_R : LAST_C;
    if (w_sel_mode)
      w_addr = 10'(w_sel_idx) * COLS10 + 10'(w_sel_pos);
    else
      w_addr = 10'(w_sel_pos) * COLS10 + 10'(w_sel_idx);
    w_base = 14'(w_addr) * WORD14;
    w_elem = mat_in[w_base +: WORD];
  end

  // Request acceptance and beat sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_idx     <= 5'd0;
      req_ready <= 1'b1;
      req_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pos   <= 5'd0;
      out_last  <= 1'b0;
    end else begin
      req_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_idx_ok) begin
              r_mode    <= req_mode;
              r_idx     <= req_idx;
              out_valid <= 1'b1;
              out_data  <= w_elem;
              out_pos   <= 5'd0;
              out_last  <= (w_sel_last == 5'd0);
              req_ready <= 1'b0;
              r_state   <= STREAM;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              req_ready <= 1'b1;
              r_state   <= IDLE;
            end else begin
              out_data <= w_elem;
              out_pos  <= w_sel_pos;
              out_last <= (w_sel_pos == w_sel_last);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MATRIX_READER_NORM_EN
  logic signed [2*WORD-1:0] w_sq;

  always_comb begin
    w_sq = $signed(out_data) * $signed(out_data);
  end

  // Sum of squares over transferred beats; cleared when a stream starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      norm_sq    <= '0;
      norm_valid <= 1'b0;
    end else begin
      norm_valid <= 1'b0;
      if (r_state == IDLE && req_valid && w_idx_ok) begin
        norm_sq <= '0;
      end else if (r_state == STREAM && w_fire) begin
        norm_sq    <= norm_sq + {6'b0, w_sq};
        norm_valid <= out_last;
      end
    end
  end
`endif

endmodule

// File: tb/tb_matrix_element_reader.sv
// Directed bench for matrix_element_reader.
// Norm checks compile in when MATRIX_READER_NORM_EN is defined.
module tb_matrix_element_reader;

  localparam int WORD = 16;
  localparam int ROWS = 24;
  localparam int COLS = 32;
  localparam int N    = WORD * ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    mat_in;
  logic            req_valid;
  logic            req_ready;
  logic            req_mode;
  logic [4:0]      req_idx;
  logic            req_err;
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] out_data;
  logic [4:0]      out_pos;
  logic            out_last;
`ifdef MATRIX_READER_NORM_EN
  logic [2*WORD+5:0] norm_sq;
  logic              norm_valid;
`endif

  logic [WORD-1:0] pat [ROWS*COLS];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_element_reader #(
    .WORD(WORD), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mat_in(mat_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mode(req_mode),
    .req_idx(req_idx),
    .req_err(req_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pos(out_pos),
    .out_last(out_last)
`ifdef MATRIX_READER_NORM_EN
    ,
    .norm_sq(norm_sq),
    .norm_valid(norm_valid)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_pat(input bit const_mode, input logic [15:0] v);
    for (int k = 0; k < ROWS*COLS; k++) begin
      pat[k] = const_mode ? v : 16'(k);
      mat_in[WORD*k +: WORD] = pat[k];
    end
  endtask

  task automatic run_stream(input bit mode, input logic [4:0] idx,
                            input bit bp);
    int n, cyc, exp_n, np, addr, d;
    logic [37:0] nm;
    logic [15:0] hd;
    logic [4:0]  hp;
    logic        hl;
    bit          stalled;
    exp_n = mode ? COLS : ROWS;
    req_mode  = mode;
    req_idx   = idx;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("first_beat_valid", out_valid, 1);
    check("busy_not_ready", req_ready, 0);
    n = 0; cyc = 0; np = 0; nm = '0; stalled = 0;
    while (n < exp_n && cyc < 400) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
`ifdef MATRIX_READER_NORM_EN
      if (norm_valid) np++;
`endif
      if (stalled) begin
        check("hold_data", out_data, hd);
        check("hold_pos", out_pos, hp);
        check("hold_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        addr = mode ? idx*COLS + n : n*COLS + idx;
        check("data", out_data, pat[addr]);
        check("pos", out_pos, n);
        check("last", out_last, (n == exp_n-1));
        d  = $signed(pat[addr]);
        nm = nm + 38'(d*d);
        n++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        hd = out_data; hp = out_pos; hl = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check("beats", n, exp_n);
    check("end_valid", out_valid, 0);
    check("end_ready", req_ready, 1);
`ifdef MATRIX_READER_NORM_EN
    check("norm_early", np, 0);
    check("norm_valid", norm_valid, 1);
    check("norm_sq_model", norm_sq, nm);
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_idx   = 5'd0;
    out_ready = 1'b1;
    load_pat(0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_err", req_err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_pos", out_pos, 0);
    check("rst_last", out_last, 0);

    run_stream(0, 5'd3, 0);
    run_stream(1, 5'd2, 0);
    run_stream(0, 5'd0, 1);
`ifdef MATRIX_READER_NORM_EN
    check("norm_col0", norm_sq, 64'd4427776);
    @(negedge clk);
    check("norm_pulse_once", norm_valid, 0);
    check("norm_hold", norm_sq, 64'd4427776);
`endif
    run_stream(0, 5'd31, 0);
    check("col31_end", out_data, 767);

    req_mode = 1'b1; req_idx = 5'd24; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("err_pulse", req_err, 1);
    check("err_valid", out_valid, 0);
    check("err_ready", req_ready, 1);
    @(negedge clk);
    check("err_clear", req_err, 0);
    check("err_valid2", out_valid, 0);

    req_mode = 1'b0; req_idx = 5'd0; req_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_pos", out_pos, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_ready", req_ready, 1);
    @(negedge clk);
    check("abort_quiet", out_valid, 0);
    run_stream(0, 5'd1, 0);

`ifdef MATRIX_READER_NORM_EN
    load_pat(1, 16'h8000);
    run_stream(1, 5'd5, 0);
    check("norm_8000", norm_sq, 64'd34359738368);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
